// File: rtl/dds_pkg.sv
// Shared types and helpers for the multi-channel DDS phase generator.
package dds_pkg;

    typedef enum logic {
        CFG_FREQ = 1'b0,
        CFG_OFFS = 1'b1
    } cfg_sel_e;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } commit_state_e;

    // Channel index width, never narrower than one bit.
    function automatic int ch_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/dds_phase_channel.sv
// One DDS channel: shadow/active tuning registers, phase accumulator and
// the registered offset-phase output stage.
module dds_phase_channel #(
    parameter int PHASE_W = 32,
    parameter int FREQ_W  = 32,
    parameter int OUT_W   = 12
) (
    input  logic               clk,
    input  logic               res_n,
    input  logic               en,
    input  logic               clr,
    input  logic               wr_freq,
    input  logic               wr_offs,
    input  logic [PHASE_W-1:0] wr_data,
    input  logic               apply,
    output logic [OUT_W-1:0]   phase,
    output logic               wrap
);

    logic [FREQ_W-1:0]  freq_shd_reg;
    logic [FREQ_W-1:0]  freq_act_reg;
    logic [PHASE_W-1:0] offs_shd_reg;
    logic [PHASE_W-1:0] offs_act_reg;
    logic [PHASE_W-1:0] acc_reg;
    logic               carry_reg;
    logic [OUT_W-1:0]   phase_reg;
    logic               wrap_reg;

    logic [PHASE_W:0]   sum_next;
    logic [PHASE_W-1:0] offs_sum;

    // Extra top bit of the sum is the accumulator carry-out.
    assign sum_next = {1'b0, acc_reg} + (PHASE_W+1)'(freq_act_reg);
    assign offs_sum = acc_reg + offs_act_reg;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            freq_shd_reg <= '0;
            offs_shd_reg <= '0;
            freq_act_reg <= '0;
            offs_act_reg <= '0;
        end else begin
            if (wr_freq) freq_shd_reg <= wr_data[FREQ_W-1:0];
            if (wr_offs) offs_shd_reg <= wr_data;
            if (apply) begin
                freq_act_reg <= freq_shd_reg;
                offs_act_reg <= offs_shd_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            acc_reg   <= '0;
            carry_reg <= 1'b0;
        end else if (clr) begin
            acc_reg   <= '0;
            carry_reg <= 1'b0;
        end else if (en) begin
            acc_reg   <= sum_next[PHASE_W-1:0];
            carry_reg <= sum_next[PHASE_W];
        end else begin
            carry_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            phase_reg <= '0;
            wrap_reg  <= 1'b0;
        end else begin
            phase_reg <= offs_sum[PHASE_W-1 -: OUT_W];
            wrap_reg  <= carry_reg;
        end
    end

    assign phase = phase_reg;
    assign wrap  = wrap_reg;

endmodule

// File: rtl/dds_phase_gen.sv
// Multi-channel DDS phase generator: config decode, commit FSM for
// phase-coherent retuning, enable pipeline and per-channel instances.
module dds_phase_gen
    import dds_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int PHASE_W  = 32,
    parameter  int FREQ_W   = 32,
    parameter  int OUT_W    = 12,
    localparam int CH_W     = ch_w(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      res_n,
    input  logic                      en,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [CH_W-1:0]           cfg_ch,
    input  logic                      cfg_sel,
    input  logic [PHASE_W-1:0]        cfg_data,
    input  logic                      commit,
    input  logic [CHANNELS-1:0]       phase_clr,
    output logic [CHANNELS*OUT_W-1:0] phase_out,
    output logic [CHANNELS-1:0]       wrap,
    output logic                      out_valid
);

    commit_state_e state_reg;
    logic          en_d1_reg;
    logic          out_valid_reg;
    logic          wr_accept;
    logic          apply;
    cfg_sel_e      sel;

    // Shadows are copied into the active set on the first enabled sample
    // after a commit, so all channels retune on the same sample.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (commit) state_reg <= PENDING;
                PENDING: if (en)     state_reg <= IDLE;
                default:             state_reg <= IDLE;
            endcase
        end
    end

    assign cfg_ready = (state_reg == IDLE);
    assign apply     = (state_reg == PENDING) && en;
    assign wr_accept = cfg_valid && cfg_ready;
    assign sel       = cfg_sel_e'(cfg_sel);

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            en_d1_reg     <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            en_d1_reg     <= en;
            out_valid_reg <= en_d1_reg;
        end
    end

    assign out_valid = out_valid_reg;

    // Out-of-range channel indices match no instance, so such writes vanish.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic hit;
        assign hit = wr_accept && (cfg_ch == CH_W'(gi));

        dds_phase_channel #(
            .PHASE_W (PHASE_W),
            .FREQ_W  (FREQ_W),
            .OUT_W   (OUT_W)
        ) u_ch (
            .clk     (clk),
            .res_n   (res_n),
            .en      (en),
            .clr     (phase_clr[gi]),
            .wr_freq (hit && (sel == CFG_FREQ)),
            .wr_offs (hit && (sel == CFG_OFFS)),
            .wr_data (cfg_data),
            .apply   (apply),
            .phase   (phase_out[gi*OUT_W +: OUT_W]),
            .wrap    (wrap[gi])
        );
    end

endmodule

// File: tb/tb_dds_phase_gen.sv
// Directed self-checking bench for dds_phase_gen (4-channel main instance,
// 5-channel instance for out-of-range channel writes).
module tb_dds_phase_gen;

    logic        clk = 1'b0;
    logic        res_n;
    logic        en, cfg_valid, cfg_sel, commit;
    logic [1:0]  cfg_ch;
    logic [31:0] cfg_data;
    logic [3:0]  phase_clr;
    logic        cfg_ready, out_valid;
    logic [47:0] phase_out;
    logic [3:0]  wrap;

    logic        b_en, b_cfg_valid, b_cfg_sel, b_commit;
    logic [2:0]  b_cfg_ch;
    logic [31:0] b_cfg_data;
    logic [4:0]  b_phase_clr;
    logic        b_cfg_ready, b_out_valid;
    logic [59:0] b_phase_out;
    logic [4:0]  b_wrap;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dds_phase_gen dut (
        .clk(clk), .res_n(res_n), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .commit(commit),
        .phase_clr(phase_clr), .phase_out(phase_out), .wrap(wrap), .out_valid(out_valid)
    );

    dds_phase_gen #(.CHANNELS(5)) dut_b (
        .clk(clk), .res_n(res_n), .en(b_en), .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready),
        .cfg_ch(b_cfg_ch), .cfg_sel(b_cfg_sel), .cfg_data(b_cfg_data), .commit(b_commit),
        .phase_clr(b_phase_clr), .phase_out(b_phase_out), .wrap(b_wrap), .out_valid(b_out_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [11:0] ph(input int c);
        return phase_out[c*12 +: 12];
    endfunction

    task automatic cfg_write(input logic [1:0] ch, input logic sel, input logic [31:0] data);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_sel   = sel;
        cfg_data  = data;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    initial begin
        res_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_sel = 1'b0; commit = 1'b0;
        cfg_ch = '0; cfg_data = '0; phase_clr = '0;
        b_en = 1'b1; b_cfg_valid = 1'b0; b_cfg_sel = 1'b0; b_commit = 1'b0;
        b_cfg_ch = '0; b_cfg_data = '0; b_phase_clr = '0;

        // Reset state
        repeat (2) tick();
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_phase_out", phase_out, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_out_valid", out_valid, 0);
        res_n = 1'b1;
        tick();

        // ch0 quarter-turn frequency, commit pending until en
        cfg_write(2'd0, 1'b0, 32'h4000_0000);
        do_commit();
        chk("pend_ready_lo", cfg_ready, 0);
        tick();
        chk("pend_ready_hold", cfg_ready, 0);
        chk("pend_ph0", ph(0), 12'h000);
        en = 1'b1;
        tick();
        chk("apply_ready_hi", cfg_ready, 1);
        chk("apply_valid_lo", out_valid, 0);
        tick();
        chk("valid_2cyc", out_valid, 1);
        chk("seq_ph0_0", ph(0), 12'h000);
        tick(); chk("seq_ph0_400", ph(0), 12'h400); chk("seq_wrap_a", wrap, 4'b0000);
        tick(); chk("seq_ph0_800", ph(0), 12'h800);
        tick(); chk("seq_ph0_c00", ph(0), 12'hC00); chk("seq_wrap_b", wrap, 4'b0000);
        tick(); chk("seq_ph0_000", ph(0), 12'h000); chk("seq_wrap_hit", wrap, 4'b0001);
        tick(); chk("seq_ph0_400b", ph(0), 12'h400); chk("seq_wrap_c", wrap, 4'b0000);

        // ch1 fixed half-turn offset
        cfg_write(2'd1, 1'b1, 32'h8000_0000);
        do_commit();
        chk("offs_pend", cfg_ready, 0);
        tick();
        chk("offs_applied_ready", cfg_ready, 1);
        tick();
        chk("offs_ph1", ph(1), 12'h800);
        chk("offs_wrap1", wrap[1], 0);
        tick();
        chk("offs_ph1_hold", ph(1), 12'h800);

        // Retune ch1/ch2; ch2 write shares the cycle with commit
        cfg_write(2'd1, 1'b0, 32'h0100_0000);
        cfg_write(2'd1, 1'b1, 32'h1000_0000);
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_sel = 1'b0; cfg_data = 32'h1000_0000;
        commit = 1'b1;
        tick();
        cfg_valid = 1'b0; commit = 1'b0;
        tick();
        chk("same_cyc_ready", cfg_ready, 1);

        // Align all accumulators, then clear ch0/ch1 only
        phase_clr = 4'hF; tick(); phase_clr = 4'h0;
        tick();
        chk("sync_ph0", ph(0), 12'h000);
        chk("sync_ph1", ph(1), 12'h100);
        chk("sync_ph2", ph(2), 12'h000);
        chk("sync_ph3", ph(3), 12'h000);
        tick();
        chk("p2_ph1", ph(1), 12'h110);
        chk("p2_ph2", ph(2), 12'h100);
        tick();
        chk("p3_ph0", ph(0), 12'h800);
        phase_clr = 4'b0011;
        tick();
        phase_clr = 4'h0;
        chk("p4_ph0", ph(0), 12'hC00);
        chk("p4_ph2", ph(2), 12'h300);
        tick();
        chk("clr_ph0", ph(0), 12'h000);
        chk("clr_ph1", ph(1), 12'h100);
        chk("clr_ph2_cont", ph(2), 12'h400);
        chk("clr_ph3", ph(3), 12'h000);
        chk("clr_wrap", wrap, 4'b0000);
        tick();
        chk("p6_ph0", ph(0), 12'h400);
        chk("p6_ph1", ph(1), 12'h110);
        chk("p6_ph2", ph(2), 12'h500);

        // Commit while en=0 waits, outputs hold
        en = 1'b0;
        phase_clr = 4'hF; tick(); phase_clr = 4'h0;
        tick(); tick();
        chk("hold_valid_lo", out_valid, 0);
        chk("hold_ph0", ph(0), 12'h000);
        chk("hold_ph1", ph(1), 12'h100);
        cfg_write(2'd0, 1'b0, 32'h2000_0000);
        do_commit();
        chk("en0_pend_ready", cfg_ready, 0);
        tick(); tick();
        chk("en0_still_pend", cfg_ready, 0);
        chk("en0_ph0_hold", ph(0), 12'h000);
        chk("en0_ph1_hold", ph(1), 12'h100);
        chk("en0_valid", out_valid, 0);
        chk("en0_wrap", wrap, 4'b0000);
        en = 1'b1;
        tick();
        chk("en1_ready", cfg_ready, 1);
        chk("en1_valid_lo", out_valid, 0);
        tick();
        chk("old_freq_step", ph(0), 12'h400);
        chk("en1_valid_hi", out_valid, 1);
        tick();
        chk("new_freq_step", ph(0), 12'h600);
        tick();
        chk("new_freq_step2", ph(0), 12'h800);

        // Out-of-range channel write on 5-channel instance
        b_cfg_valid = 1'b1; b_cfg_ch = 3'd5; b_cfg_sel = 1'b0; b_cfg_data = 32'hFFFF_FFFF;
        tick();
        b_cfg_valid = 1'b0;
        b_commit = 1'b1; tick(); b_commit = 1'b0;
        repeat (4) tick();
        chk("oor_phase", b_phase_out, 60'h0);
        chk("oor_wrap", b_wrap, 5'b00000);
        b_cfg_valid = 1'b1; b_cfg_ch = 3'd4; b_cfg_data = 32'h8000_0000;
        tick();
        b_cfg_valid = 1'b0;
        b_commit = 1'b1; tick(); b_commit = 1'b0;
        tick(); tick(); tick();
        chk("b_ch4_800", b_phase_out[59:48], 12'h800);
        tick();
        chk("b_ch4_000", b_phase_out[59:48], 12'h000);
        chk("b_wrap4", b_wrap, 5'b10000);

        // Reset with a commit pending
        en = 1'b0;
        cfg_write(2'd0, 1'b0, 32'h1234_5678);
        do_commit();
        chk("prerst_pend", cfg_ready, 0);
        res_n = 1'b0;
        #1;
        chk("async_rst_phase", phase_out, 0);
        chk("async_rst_wrap", wrap, 0);
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_ready", cfg_ready, 1);
        tick();
        res_n = 1'b1;
        en = 1'b1;
        do_commit();
        repeat (5) tick();
        chk("postrst_phase", phase_out, 0);
        chk("postrst_valid", out_valid, 1);
        chk("postrst_ready", cfg_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
